// File: rtl/gsr_pur_pkg.sv
// +--------------------------------------------------------------------------+
// | gsr_pur_pkg : shared constants and helpers for the global reset nets.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package gsr_pur_pkg;

  localparam string MODE_ENABLED  = "ENABLED";
  localparam string MODE_DISABLED = "DISABLED";

  // Reset nets are active-low.
  localparam logic RUN  = 1'b1;
  localparam logic HOLD = 1'b0;

  localparam int GSR_CNT_W = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gsr_sync.sv
// +--------------------------------------------------------------------------+
// | gsr_sync : multi-flop synchroniser with synchronous reset to RESET_VAL.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module gsr_sync #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic              stage0_q;
  logic [STAGES-2:0] tail_q;
  logic              stage0_clean;

  // Unknown values captured by the first flop are resolved here so they stay there.
  assign stage0_clean = (stage0_q === 1'b1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage0_q <= RESET_VAL;
      tail_q   <= {(STAGES-1){RESET_VAL}};
    end else begin
      stage0_q <= d_i;
      tail_q   <= (tail_q << 1) | (STAGES-1)'(stage0_clean);
    end
  end

  assign q_o = tail_q[STAGES-2];

endmodule

`default_nettype wire

// File: rtl/gsr_pur_assign.sv
// +--------------------------------------------------------------------------+
// | gsr_pur_assign : generates the chip-level GSR/PUR active-low reset nets. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module gsr_pur_assign
  import gsr_pur_pkg::*;
#(
  parameter int    PUR_CYCLES     = 16,
  parameter int    GSR_MIN_CYCLES = 4,
  parameter int    SYNC_STAGES    = 2,
  parameter string GSR_MODE       = "ENABLED"
) (
  output logic GSR_sig,
  output logic PUR_sig,
  input  logic CLK,
  input  logic RSTB,
  input  logic GSR_N,
  output logic SR
);

  localparam int                   PUR_W    = clog2(PUR_CYCLES + 1);
  localparam logic [PUR_W-1:0]     PUR_MAX  = PUR_W'(PUR_CYCLES);
  localparam logic [GSR_CNT_W-1:0] GSR_LOAD = GSR_CNT_W'(GSR_MIN_CYCLES);
  localparam bit                   GSR_EN   = (GSR_MODE != MODE_DISABLED);

  logic [PUR_W-1:0]     pur_cnt_q, pur_cnt_d;
  logic                 pur_q, pur_d;
  logic [GSR_CNT_W-1:0] gsr_cnt_q, gsr_cnt_d;
  logic                 gsr_q, gsr_d;
  logic                 req;

  // ---------------- power-up sequencer (saturating, never wraps) ----------
  always_comb begin
    pur_cnt_d = pur_cnt_q;
    if (pur_cnt_q != PUR_MAX) pur_cnt_d = pur_cnt_q + PUR_W'(1);
    pur_d = (pur_cnt_d == PUR_MAX) ? RUN : HOLD;
  end

  always_ff @(posedge CLK) begin
    if (RSTB) begin
      pur_cnt_q <= '0;
      pur_q     <= HOLD;
    end else begin
      pur_cnt_q <= pur_cnt_d;
      pur_q     <= pur_d;
    end
  end

  // ---------------- GSR request path -------------------------------------
  generate
    if (GSR_EN) begin : g_sync_en
      logic sync_last;

      gsr_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
      ) u_gsr_sync (
        .clk_i (CLK),
        .rst_i (RSTB),
        .d_i   (GSR_N),
        .q_o   (sync_last)
      );

      assign req = ~sync_last;
    end else begin : g_sync_dis
      assign req = 1'b0;
    end
  endgenerate

  // Any request reloads the stretch, so re-assertion never opens a gap.
  always_comb begin
    gsr_cnt_d = gsr_cnt_q;
    if (req) begin
      gsr_cnt_d = GSR_LOAD;
    end else if (gsr_cnt_q != '0) begin
      gsr_cnt_d = gsr_cnt_q - GSR_CNT_W'(1);
    end
    gsr_d = (req || (gsr_cnt_q != '0)) ? HOLD : RUN;
  end

  always_ff @(posedge CLK) begin
    if (RSTB) begin
      gsr_cnt_q <= '0;
      gsr_q     <= HOLD;
    end else begin
      gsr_cnt_q <= gsr_cnt_d;
      gsr_q     <= gsr_d;
    end
  end

  assign GSR_sig = gsr_q;
  assign PUR_sig = pur_q;
  assign SR      = ~(gsr_q & pur_q);

endmodule

`default_nettype wire

// File: tb/tb_gsr_pur_assign.sv
// +--------------------------------------------------------------------------+
// | tb_gsr_pur_assign : scoreboard bench for enabled, disabled, long-PUR.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_gsr_pur_assign;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb_a, rstb_c, gsr_n_a, gsr_n_b;
  logic gsr_a, pur_a, sr_a;
  logic gsr_b, pur_b, sr_b;
  logic gsr_c, pur_c, sr_c;

  gsr_pur_assign u_dut_a (
    .GSR_sig (gsr_a), .PUR_sig (pur_a), .CLK (clk),
    .RSTB (rstb_a), .GSR_N (gsr_n_a), .SR (sr_a)
  );

  gsr_pur_assign #(.GSR_MODE ("DISABLED")) u_dut_b (
    .GSR_sig (gsr_b), .PUR_sig (pur_b), .CLK (clk),
    .RSTB (rstb_a), .GSR_N (gsr_n_b), .SR (sr_b)
  );

  gsr_pur_assign #(.PUR_CYCLES (65535)) u_dut_c (
    .GSR_sig (gsr_c), .PUR_sig (pur_c), .CLK (clk),
    .RSTB (rstb_c), .GSR_N (1'b1), .SR (sr_c)
  );

  typedef struct packed {
    int       pur_cnt;
    bit       pur;
    bit [3:0] sync;
    int       gcnt;
    bit       gsr;
  } mdl_t;

  typedef struct packed {
    bit pa, ga, pb, gb, pc, gc;
  } exp_t;

  exp_t sb[$];
  mdl_t ma, mb, mc;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_rel_c = 0;
  int   rises_c = 0;
  int   rise_at_c = 0;
  bit   prev_pur_c = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Behavioural reference of one clock edge.
  function automatic mdl_t mdl_step(input mdl_t s, input bit rst, input bit gn,
                                    input int pc, input int mc_, input int st, input bit en);
    mdl_t n;
    bit   req;
    n = s;
    if (rst) begin
      n.pur_cnt = 0; n.pur = 1'b0; n.gsr = 1'b0; n.gcnt = 0; n.sync = '0;
    end else begin
      n.pur_cnt = (s.pur_cnt < pc) ? s.pur_cnt + 1 : pc;
      n.pur     = (n.pur_cnt == pc);
      req       = en && !s.sync[st-1];
      n.gsr     = !(req || (s.gcnt != 0));
      n.gcnt    = req ? mc_ : ((s.gcnt > 0) ? s.gcnt - 1 : 0);
      n.sync    = {s.sync[2:0], gn};
    end
    return n;
  endfunction

  task automatic step();
    exp_t e;
    ma = mdl_step(ma, rstb_a, gsr_n_a, 16, 4, 2, 1'b1);
    mb = mdl_step(mb, rstb_a, gsr_n_b, 16, 4, 2, 1'b0);
    mc = mdl_step(mc, rstb_c, 1'b1, 65535, 4, 2, 1'b1);
    sb.push_back('{ma.pur, ma.gsr, mb.pur, mb.gsr, mc.pur, mc.gsr});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("A_pur", pur_a, e.pa);
    chk("A_gsr", gsr_a, e.ga);
    chk("A_sr",  sr_a,  !(e.pa && e.ga));
    chk("B_pur", pur_b, e.pb);
    chk("B_gsr", gsr_b, e.gb);
    chk("B_sr",  sr_b,  !(e.pb && e.gb));
    chk("C_pur", pur_c, e.pc);
    chk("C_sr",  sr_c,  !(e.pc && e.gc));
    if (!rstb_c) n_rel_c++;
    if (pur_c && !prev_pur_c) begin
      rises_c++;
      rise_at_c = n_rel_c;
    end
    prev_pur_c = pur_c;
  endtask

  initial begin
    int rise_p, rise_g, fall_g, n_rise, n_low;
    bit prev;
    bit pat [18] = '{0,0,1,1,0,0,1,1,1,1,1,1,1,1,1,1,1,1};

    ma = '0; mb = '0; mc = '0;
    rstb_a = 1'b1; rstb_c = 1'b1; gsr_n_a = 1'b1; gsr_n_b = 1'b1;
    repeat (3) step();
    chk("rst_pur", pur_a, 0);
    chk("rst_gsr", gsr_a, 0);
    chk("rst_sr",  sr_a,  1);

    // Power-up sequence
    rstb_a = 1'b0; rstb_c = 1'b0;
    rise_p = 0; rise_g = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 1) chk("dis_gsr_first", gsr_b, 1);
      if (pur_a && rise_p == 0) rise_p = e;
      if (gsr_a && rise_g == 0) rise_g = e;
    end
    chk("pu_pur_edge", rise_p, 16);
    chk("pu_gsr_edge", rise_g, 7);
    chk("pu_sr", sr_a, 0);

    // Single long GSR pulse; the disabled instance sees random toggling
    gsr_n_a = 1'b0; fall_g = 0;
    for (int e = 1; e <= 10; e++) begin
      gsr_n_b = 1'($urandom);
      step();
      if (!gsr_a && fall_g == 0) fall_g = e;
    end
    gsr_n_a = 1'b1; rise_g = 0;
    for (int e = 1; e <= 15; e++) begin
      gsr_n_b = 1'($urandom);
      step();
      if (gsr_a && rise_g == 0) rise_g = e;
    end
    chk("pulse_fall_edge", fall_g, 3);
    chk("pulse_rise_edge", rise_g, 7);
    chk("pulse_pur", pur_a, 1);
    chk("dis_gsr_hold", gsr_b, 1);

    // Re-trigger during stretch must give one continuous low window
    n_rise = 0; n_low = 0; prev = gsr_a;
    for (int i = 0; i < 18; i++) begin
      gsr_n_a = pat[i];
      step();
      if (gsr_a && !prev) n_rise++;
      if (!gsr_a) n_low++;
      prev = gsr_a;
    end
    chk("retrig_rises", n_rise, 1);
    chk("retrig_low_len", n_low, 10);

    // Reset in the middle of the PUR count
    rstb_a = 1'b1; step();
    rstb_a = 1'b0; repeat (8) step();
    rstb_a = 1'b1; step();
    chk("mid_pur", pur_a, 0);
    chk("mid_gsr", gsr_a, 0);
    rstb_a = 1'b0; rise_p = 0; rise_g = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (pur_a && rise_p == 0) rise_p = e;
      if (gsr_a && rise_g == 0) rise_g = e;
    end
    chk("mid_pur_edge", rise_p, 16);
    chk("mid_gsr_edge", rise_g, 7);

    // Long PUR instance: saturation, no wrap
    while (n_rel_c < 70000) step();
    chk("sat_rises", rises_c, 1);
    chk("sat_edge", rise_at_c, 65535);
    chk("sat_pur", pur_c, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gsr_pur_assign.md
Name: gsr_pur_assign

Overview:
- Generates the two global chip-level reset nets consumed by every I/O primitive model (e.g. DDR gearbox cells): GSR_sig (global set/reset) and PUR_sig (power-up reset).
- Both nets are active-low: 1 = run, 0 = hold in reset.
- Consumers compute SRN = GSR_sig & PUR_sig (or PUR_sig alone when their GSR use is disabled).
- One instance sits at the top of the design; all primitives read its outputs.

Parameters:
- PUR_CYCLES, 16: clock edges PUR_sig stays low after RSTB release (1..65535).
- GSR_MIN_CYCLES, 4: minimum extra low time of GSR_sig after the synchronised request ends (0..255).
- SYNC_STAGES, 2: synchroniser depth for GSR_N (2..4).
- GSR_MODE, "ENABLED": "ENABLED" or "DISABLED". When disabled, GSR_N is ignored.

Ports:
- CLK  input  1  free-running system clock; all state updates on rising edge.
- RSTB  input  1  reset, synchronous, active-high.
- GSR_N  input  1  asynchronous global set/reset request, active-low.
- GSR_sig  output  1  global set/reset net, active-low, registered.
- PUR_sig  output  1  power-up reset net, active-low, registered.
- SR  output  1  combined reset = ~(GSR_sig & PUR_sig), combinational, active-high.
- Declared port order is GSR_sig, PUR_sig, CLK, RSTB, GSR_N, so that two-output positional instantiation binds the nets.

Behaviour:
- Reset: on any rising edge with RSTB=1:
  - PUR_sig=0, GSR_sig=0, so SR=1.
  - PUR counter cleared to 0.
  - GSR stretch counter cleared to 0.
  - All synchroniser flops set to 0 (request asserted).
- Reset is sampled only on CLK edges; no asynchronous path. Reset mid-operation restarts both sequences from the beginning.
- PUR sequencer:
  - Counter is ceil(log2(PUR_CYCLES+1)) bits.
  - Increments on each edge with RSTB=0 and saturates at PUR_CYCLES; never wraps.
  - PUR_sig is registered and becomes 1 on exactly the PUR_CYCLES-th rising edge after the first edge that samples RSTB=0. It stays 1 until the next RSTB.
- GSR synchroniser:
  - GSR_N passes through SYNC_STAGES flops.
  - req = NOT(last stage).
  - GSR_N is never used combinationally.
- GSR stretch:
  - Counter is 8 bits. Each edge with req=1 loads GSR_MIN_CYCLES.
  - Each edge with req=0 and counter>0 decrements it.
  - GSR_sig <= ~(req | (counter != 0)).
  - GSR_N falling edge → GSR_sig low after SYNC_STAGES+1 edges.
  - GSR_N rising edge → GSR_sig high after SYNC_STAGES+GSR_MIN_CYCLES+1 edges.
  - A pulse shorter than one CLK period may be missed; no capture is required.
  - Re-assertion during stretch reloads the counter.
- GSR_MODE="DISABLED": synchroniser and counter are held at their non-asserting values; GSR_sig becomes 1 on the first edge after RSTB release.
- Independence: GSR and PUR run independently. SR reflects either one.
- Simultaneous RSTB=1 and GSR_N=0: RSTB wins (everything in reset state).
- X/Z on GSR_N after synchronisation must not propagate beyond the first stage in simulation.

Decomposition:
- Shared package gsr_pur_pkg:
  - GSR_MODE string constants "ENABLED"/"DISABLED".
  - Function clog2 used for counter widths.
  - Active-low level constants RUN=1, HOLD=0.
- One natural sub-module: gsr_sync, a SYNC_STAGES-deep synchroniser with synchronous active-high reset to a configurable value. The PUR counter stays inline.

Test Plan:
- Power-up: RSTB=1 for 3 edges, then 0, GSR_N=1, PUR_CYCLES=16 → PUR_sig=0 through edge 15, 1 at edge 16. GSR_sig=1 at edge SYNC_STAGES+GSR_MIN_CYCLES+1 (=7). SR=0 from edge 16.
- GSR pulse after PUR done: GSR_N low for 10 cycles → GSR_sig low 3 edges after the fall and high 7 edges after the rise. SR tracks it. PUR_sig stays 1.
- Re-trigger: GSR_N low 2 cycles, high 2, low 2 (GSR_MIN_CYCLES=4) → GSR_sig one continuous low window with no glitch high.
- Reset mid-run: RSTB=1 for one edge at PUR count 8 → PUR_sig and GSR_sig return to 0; PUR sequence restarts and completes after a full 16 edges.
- GSR_MODE="DISABLED": GSR_N toggling → GSR_sig=1 from the first post-reset edge; SR depends only on PUR_sig.
- Saturation: hold RSTB=0 for 70000 cycles with PUR_CYCLES=65535 → PUR_sig rises once and never drops (no wrap).
